// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a small MIPS subset.
// It sequences fetch, decode, execute, memory and writeback, and drives the
// fetch unit so the PC holds for the whole instruction and moves exactly once,
// in the instruction's last state.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic [2:0]       npc_sel,
   output logic             ir_we,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wd_sel,
   output logic             alu_src,
   output logic [2:0]       alu_op,
   output logic [1:0]       ext_op,
   output logic             mem_req,
   output logic             mem_we,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   stateT            r_state;
   stateT            w_nextState;
   logic [5:0]       r_opcode;
   logic [5:0]       r_funct;
   logic             r_isNop;
   logic [CNT_W-1:0] r_retired;

   logic w_isRtype;
   logic w_isAddu;
   logic w_isSubu;
   logic w_isJr;
   logic w_isJ;
   logic w_isJal;
   logic w_isBeq;
   logic w_isOri;
   logic w_isLui;
   logic w_isLw;
   logic w_isSw;
   logic w_isLegal;

   // The nop check uses the whole word, so a nonzero shift with
   // opcode 0 / funct 0 is rejected as an unsupported encoding.
   assign w_isRtype = (r_opcode == OP_RTYPE);
   assign w_isAddu  = w_isRtype && (r_funct == FN_ADDU);
   assign w_isSubu  = w_isRtype && (r_funct == FN_SUBU);
   assign w_isJr    = w_isRtype && (r_funct == FN_JR);
   assign w_isJ     = (r_opcode == OP_J);
   assign w_isJal   = (r_opcode == OP_JAL);
   assign w_isBeq   = (r_opcode == OP_BEQ);
   assign w_isOri   = (r_opcode == OP_ORI);
   assign w_isLui   = (r_opcode == OP_LUI);
   assign w_isLw    = (r_opcode == OP_LW);
   assign w_isSw    = (r_opcode == OP_SW);
   assign w_isLegal = w_isAddu | w_isSubu | w_isJr | w_isJ | w_isJal | w_isBeq |
                      w_isOri | w_isLui | w_isLw | w_isSw | r_isNop;

   assign state   = r_state;
   assign retired = r_retired;

   // Per-state control outputs and next-state decode; everything is forced
   // quiet while reset is high so an abandoned instruction never commits.
   always_comb begin
      pc_we       = 1'b0;
      npc_sel     = 3'd0;
      ir_we       = 1'b0;
      reg_we      = 1'b0;
      reg_dst     = 2'd0;
      wd_sel      = 2'd0;
      alu_src     = 1'b0;
      alu_op      = 3'd0;
      ext_op      = 2'd0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      illegal     = 1'b0;
      w_nextState = S_IF;

      if (r_state == S_EX || r_state == S_MEM || r_state == S_WB) begin
         if (w_isSubu) begin
            alu_op = 3'd1;
         end else if (w_isOri) begin
            alu_op  = 3'd2;
            alu_src = 1'b1;
         end else if (w_isLui) begin
            alu_op  = 3'd3;
            alu_src = 1'b1;
         end else if (w_isLw || w_isSw) begin
            alu_src = 1'b1;
            ext_op  = 2'd1;
         end else if (w_isBeq) begin
            alu_op = 3'd1;
            ext_op = 2'd1;
         end
      end

      case (r_state)
         S_IF: begin
            ir_we       = 1'b1;
            w_nextState = S_ID;
         end
         S_ID: begin
            if (w_isJ) begin
               pc_we   = 1'b1;
               npc_sel = 3'd3;
            end else if (w_isJr) begin
               pc_we   = 1'b1;
               npc_sel = 3'd2;
            end else if (w_isJal) begin
               w_nextState = S_WB;
            end else if (r_isNop) begin
               pc_we = 1'b1;
            end else if (!w_isLegal) begin
               pc_we   = 1'b1;
               illegal = 1'b1;
            end else begin
               w_nextState = S_EX;
            end
         end
         S_EX: begin
            if (w_isLw || w_isSw) begin
               w_nextState = S_MEM;
            end else if (w_isBeq) begin
               pc_we   = 1'b1;
               npc_sel = alu_zero ? 3'd1 : 3'd0;
            end else begin
               w_nextState = S_WB;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = w_isSw;
            if (!mem_ready) begin
               w_nextState = S_MEM;
            end else if (w_isSw) begin
               pc_we = 1'b1;
            end else begin
               w_nextState = S_WB;
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
            if (w_isJal) begin
               reg_dst = 2'd2;
               wd_sel  = 2'd2;
               npc_sel = 3'd3;
            end else if (w_isRtype) begin
               reg_dst = 2'd1;
            end else if (w_isLw) begin
               wd_sel = 2'd1;
            end
         end
         default: begin
            w_nextState = S_IF;
         end
      endcase

      if (reset) begin
         pc_we       = 1'b0;
         npc_sel     = 3'd0;
         ir_we       = 1'b0;
         reg_we      = 1'b0;
         reg_dst     = 2'd0;
         wd_sel      = 2'd0;
         alu_src     = 1'b0;
         alu_op      = 3'd0;
         ext_op      = 2'd0;
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         illegal     = 1'b0;
         w_nextState = S_IF;
      end
   end

   // State register, instruction field capture in fetch, and the retired
   // counter, which advances on every PC update and simply wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IF;
         r_opcode  <= 6'd0;
         r_funct   <= 6'd0;
         r_isNop   <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == S_IF) begin
            r_opcode <= instr[31:26];
            r_funct  <= instr[5:0];
            r_isNop  <= (instr == 32'd0);
         end
         if (pc_we) begin
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

endmodule
